blink_scheduler: RTL and testbench
==================================

Name: blink_scheduler

Overview:
Programmable blink timing controller for the VGA text pipeline. It shares one prescaler among CHANNELS independent blink generators (e.g. ch0 = cursor, ch1 = blinking-attribute text), each with its own ON/OFF duration counted in ticks. A register-write port loads shadow durations. Shadow values are committed only on frame_start, so blink changes never tear mid-frame. Outputs feed the character/attribute renderer.

Parameters:
CHANNELS, 2, number of blink channels (1..8)
TICK_DIV, 500_000, clk cycles per tick (10 ms at 50 MHz); must be >= 2
DUR_W, 8, width of duration registers, in ticks
DEFAULT_ON, 50, reset ON duration for every channel, in ticks
DEFAULT_OFF, 50, reset OFF duration for every channel, in ticks

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cfg_we  in  1  write strobe for the shadow duration registers; a write is accepted in every cycle it is high
cfg_addr  in  $clog2(CHANNELS)+1  bit0 selects ON (0) or OFF (1); upper bits select the channel
cfg_data  in  DUR_W  duration value to write
frame_start  in  1  one-cycle pulse at the start of vertical blanking
blink  out  CHANNELS  per-channel blink level (1 = visible)
pending  out  CHANNELS  per-channel flag: the shadow holds an uncommitted write

Behaviour:
- Reset (sync, takes priority over all other inputs): prescaler = 0; shadow and active ON durations = DEFAULT_ON; shadow and active OFF durations = DEFAULT_OFF; every channel in ON phase with rem = DEFAULT_ON-1; blink = all 1; pending = 0.
- Prescaler: counts 0..TICK_DIV-1 and wraps to 0. tick = 1 for the single cycle where the count equals TICK_DIV-1.
- Per-channel FSM states:
  - ON: blink = 1. On tick: if rem == 0, go to OFF and set rem = off_dur-1; else rem -= 1.
  - OFF: blink = 0. On tick: if rem == 0, go to ON and set rem = on_dur-1; else rem -= 1.
  - Result: each phase lasts exactly dur ticks. Period = (on_dur + off_dur) * TICK_DIV cycles.
- Degenerate durations, evaluated on the active values:
  - on_dur == 0: blink forced 0 (always off).
  - on_dur != 0 and off_dur == 0: blink forced 1 (always on).
  - In both cases the FSM is held in ON with rem = 0. The output is combinational from state plus the degenerate flags, with zero latency after commit.
- Config write: when cfg_we = 1, cfg_data goes to shadow[ch][bit0] and pending[ch] is set. Writes to channel >= CHANNELS are ignored and set no flag.
- Commit: on frame_start, every channel with pending = 1 copies both shadow values to active, restarts in ON with rem = new on_dur-1, and clears pending.
  - blink reflects the new state on the cycle after frame_start.
  - Channels with pending = 0 are not disturbed.
- Simultaneous events:
  - frame_start and cfg_we in the same cycle: the commit uses the shadow value from before the write. The write lands in the shadow and pending for that channel stays/becomes 1, so it is committed on the next frame.
  - frame_start and tick in the same cycle on a committing channel: the commit wins and the tick is ignored for that channel.
- Prescaler is free-running and is not reset by commits, so channels share tick alignment.
- Arithmetic: rem is DUR_W bits and is never decremented below 0. dur-1 is computed only when dur != 0.

Test Plan:
1. TICK_DIV=4, defaults ON=2/OFF=3, release reset -> blink[0] = 1 for 8 cycles, 0 for 12 cycles, then repeats with period 20; all channels identical.
2. Write ch1 ON=1 (addr 2'b10, data 1) and OFF=1 (addr 2'b11, data 1) -> pending = 2'b10 and ch1 output unchanged. Pulse frame_start -> next cycle pending = 0 and ch1 toggles every 4 cycles starting in ON. ch0 phase is undisturbed.
3. Write ch0 ON=0 and commit -> blink[0] = 0 constantly. Then write ON=5, OFF=0 and commit -> blink[0] = 1 constantly.
4. cfg_we (ch0 ON=7) in the same cycle as frame_start -> old shadow committed and pending[0] = 1 afterwards. ON=7 takes effect at the following frame_start.
5. Write to cfg_addr selecting channel 2 with CHANNELS=2 -> no pending change and no output change.
6. Assert reset mid-OFF phase after custom config -> next cycle blink = all 1, pending = 0, and timing matches defaults exactly as in scenario 1.

Source files
------------

// File: rtl/blink_scheduler.sv
// Multi-channel blink timing controller: one shared tick prescaler drives per-channel
// ON/OFF phase counters whose durations are double-buffered and committed on frame_start.
module blink_scheduler #(
   parameter int CHANNELS    = 2,
   parameter int TICK_DIV    = 500_000,
   parameter int DUR_W       = 8,
   parameter int DEFAULT_ON  = 50,
   parameter int DEFAULT_OFF = 50
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      cfg_we,
   input  logic [$clog2(CHANNELS):0] cfg_addr,
   input  logic [DUR_W-1:0]          cfg_data,
   input  logic                      frame_start,
   output logic [CHANNELS-1:0]       blink,
   output logic [CHANNELS-1:0]       pending
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [DUR_W-1:0] DEF_ON  = DUR_W'(DEFAULT_ON);
   localparam logic [DUR_W-1:0] DEF_OFF = DUR_W'(DEFAULT_OFF);
   localparam logic [DUR_W-1:0] DEF_REM = (DEFAULT_ON > 0) ? DUR_W'(DEFAULT_ON - 1) : '0;

   typedef enum logic {
      PH_ON  = 1'b0,
      PH_OFF = 1'b1
   } phase_e;

   logic [PW-1:0]       presc_q;
   logic                tick;

   phase_e              phase_q   [CHANNELS];
   logic [DUR_W-1:0]    rem_q     [CHANNELS];
   logic [DUR_W-1:0]    sh_on_q   [CHANNELS];
   logic [DUR_W-1:0]    sh_off_q  [CHANNELS];
   logic [DUR_W-1:0]    act_on_q  [CHANNELS];
   logic [DUR_W-1:0]    act_off_q [CHANNELS];
   logic [CHANNELS-1:0] pending_q;

   logic [CHANNELS-1:0] wr_on;
   logic [CHANNELS-1:0] wr_off;

   assign tick    = (presc_q == PW'(TICK_DIV - 1));
   assign pending = pending_q;

   // Write decode and output level; out-of-range channel numbers simply match nothing.
   always_comb begin
      wr_on  = '0;
      wr_off = '0;
      blink  = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (cfg_we && (int'(cfg_addr >> 1) == c)) begin
            wr_on[c]  = ~cfg_addr[0];
            wr_off[c] = cfg_addr[0];
         end
         if (act_on_q[c] == '0) begin
            blink[c] = 1'b0;
         end else if (act_off_q[c] == '0) begin
            blink[c] = 1'b1;
         end else begin
            blink[c] = (phase_q[c] == PH_ON);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         presc_q   <= '0;
         pending_q <= '0;
         for (int c = 0; c < CHANNELS; c++) begin
            sh_on_q[c]   <= DEF_ON;
            sh_off_q[c]  <= DEF_OFF;
            act_on_q[c]  <= DEF_ON;
            act_off_q[c] <= DEF_OFF;
            phase_q[c]   <= PH_ON;
            rem_q[c]     <= DEF_REM;
         end
      end else begin
         presc_q <= tick ? '0 : presc_q + PW'(1);
         for (int c = 0; c < CHANNELS; c++) begin
            if (wr_on[c]) sh_on_q[c] <= cfg_data;
            if (wr_off[c]) sh_off_q[c] <= cfg_data;

            // Commit reads the shadow before this cycle's write and overrides any tick.
            if (frame_start && pending_q[c]) begin
               act_on_q[c]  <= sh_on_q[c];
               act_off_q[c] <= sh_off_q[c];
               phase_q[c]   <= PH_ON;
               if (sh_on_q[c] != '0 && sh_off_q[c] != '0) begin
                  rem_q[c] <= sh_on_q[c] - DUR_W'(1);
               end else begin
                  rem_q[c] <= '0;
               end
            end else if (act_on_q[c] == '0 || act_off_q[c] == '0) begin
               phase_q[c] <= PH_ON;
               rem_q[c]   <= '0;
            end else if (tick) begin
               if (rem_q[c] == '0) begin
                  if (phase_q[c] == PH_ON) begin
                     phase_q[c] <= PH_OFF;
                     rem_q[c]   <= act_off_q[c] - DUR_W'(1);
                  end else begin
                     phase_q[c] <= PH_ON;
                     rem_q[c]   <= act_on_q[c] - DUR_W'(1);
                  end
               end else begin
                  rem_q[c] <= rem_q[c] - DUR_W'(1);
               end
            end

            if (wr_on[c] || wr_off[c]) begin
               pending_q[c] <= 1'b1;
            end else if (frame_start) begin
               pending_q[c] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_blink_scheduler.sv
// Directed bench for blink_scheduler: TICK_DIV=4, defaults ON=2/OFF=3, plus a
// three-channel instance for out-of-range address handling.
module tb_blink_scheduler;

   logic       clk = 1'b0;
   logic       reset;
   logic       cfg_we;
   logic [1:0] cfg_addr;
   logic [7:0] cfg_data;
   logic       frame_start;
   logic [1:0] blink;
   logic [1:0] pending;

   logic       cfg_we3;
   logic [2:0] cfg_addr3;
   logic [7:0] cfg_data3;
   logic       frame_start3;
   logic [2:0] blink3;
   logic [2:0] pending3;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   always #5 clk = ~clk;

   blink_scheduler #(
      .CHANNELS(2), .TICK_DIV(4), .DUR_W(8), .DEFAULT_ON(2), .DEFAULT_OFF(3)
   ) u_dut (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_data(cfg_data), .frame_start(frame_start), .blink(blink), .pending(pending)
   );

   blink_scheduler #(
      .CHANNELS(3), .TICK_DIV(4), .DUR_W(8), .DEFAULT_ON(2), .DEFAULT_OFF(3)
   ) u_dut3 (
      .clk(clk), .reset(reset), .cfg_we(cfg_we3), .cfg_addr(cfg_addr3),
      .cfg_data(cfg_data3), .frame_start(frame_start3), .blink(blink3), .pending(pending3)
   );

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Default ON=2/OFF=3 at 4 clocks per tick: 8 cycles on, 12 off, from reset release.
   function automatic logic def_lvl(input int c);
      return (c % 20) < 8;
   endfunction

   // ch1 after its ON=1/OFF=1 commit at cycle 43: 4 on, 4 off from cycle 44.
   function automatic logic ch1_lvl(input int c);
      return (((c - 44) / 4) % 2) == 0;
   endfunction

   initial begin
      reset        = 1'b1;
      cfg_we       = 1'b0;
      cfg_addr     = '0;
      cfg_data     = '0;
      frame_start  = 1'b0;
      cfg_we3      = 1'b0;
      cfg_addr3    = '0;
      cfg_data3    = '0;
      frame_start3 = 1'b0;
      repeat (3) step();
      cyc = 0;
      chk("reset_blink", 8'(blink), 8'h03);
      chk("reset_pending", 8'(pending), 8'h00);
      reset = 1'b0;

      // Default timing, period 20
      for (int c = 0; c < 40; c++) begin
         chk("default_timing", 8'(blink), 8'({2{def_lvl(c)}}));
         step();
      end

      // ch1 ON=1/OFF=1, commit aligned with a tick
      cfg_we = 1'b1; cfg_addr = 2'b10; cfg_data = 8'd1;
      step();
      cfg_addr = 2'b11; cfg_data = 8'd1;
      step();
      cfg_we = 1'b0;
      chk("ch1_pending", 8'(pending), 8'h02);
      chk("ch1_pre_commit", 8'(blink), 8'h03);
      step();
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      chk("ch1_commit_pending", 8'(pending), 8'h00);
      for (int c = 44; c < 64; c++) begin
         chk("ch1_fast", 8'(blink), 8'({ch1_lvl(c), (((c - 40) % 20) < 8)}));
         step();
      end

      // ch0 ON=0 -> forced off
      cfg_we = 1'b1; cfg_addr = 2'b00; cfg_data = 8'd0;
      step();
      cfg_we = 1'b0; frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      for (int c = 66; c < 74; c++) begin
         chk("ch0_on_zero", 8'(blink), 8'({ch1_lvl(c), 1'b0}));
         step();
      end

      // ch0 ON=5/OFF=0 -> forced on
      cfg_we = 1'b1; cfg_addr = 2'b00; cfg_data = 8'd5;
      step();
      cfg_addr = 2'b01; cfg_data = 8'd0;
      step();
      cfg_we = 1'b0; frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      chk("ch0_off_zero_pending", 8'(pending), 8'h00);
      for (int c = 77; c < 89; c++) begin
         chk("ch0_off_zero", 8'(blink), 8'({ch1_lvl(c), 1'b1}));
         step();
      end

      // Write coinciding with commit: old shadow (ON=5/OFF=2) commits, ON=7 stays pending
      cfg_we = 1'b1; cfg_addr = 2'b01; cfg_data = 8'd2;
      step();
      chk("coinc_pre_pending", 8'(pending), 8'h01);
      cfg_addr = 2'b00; cfg_data = 8'd7; frame_start = 1'b1;
      step();
      cfg_we = 1'b0; frame_start = 1'b0;
      chk("coinc_pending_kept", 8'(pending), 8'h01);
      for (int c = 91; c < 116; c++) begin
         chk("coinc_old_shadow", 8'(blink), 8'({ch1_lvl(c), (c <= 107)}));
         step();
      end
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      chk("coinc_second_commit", 8'(pending), 8'h00);
      for (int c = 117; c < 152; c++) begin
         chk("coinc_new_on7", 8'(blink), 8'({ch1_lvl(c), (c <= 143)}));
         step();
      end

      // Out-of-range channel on the three-channel instance
      cfg_we3 = 1'b1; cfg_addr3 = 3'b110; cfg_data3 = 8'd1;
      step();
      cfg_addr3 = 3'b111; cfg_data3 = 8'd0;
      step();
      cfg_we3 = 1'b0;
      chk("oor_pending", 8'(pending3), 8'h00);
      for (int c = 154; c < 162; c++) begin
         chk("oor_blink", 8'(blink3), 8'({3{def_lvl(c)}}));
         step();
      end
      frame_start3 = 1'b1;
      step();
      frame_start3 = 1'b0;
      chk("oor_after_frame", 8'(blink3), 8'({3{def_lvl(cyc)}}));
      cfg_we3 = 1'b1; cfg_addr3 = 3'b100; cfg_data3 = 8'd1;
      step();
      cfg_we3 = 1'b0;
      chk("ch2_valid_pending", 8'(pending3), 8'h04);

      // Reset mid-OFF with custom config and an uncommitted write
      while (cyc < 181) step();
      cfg_we = 1'b1; cfg_addr = 2'b10; cfg_data = 8'd3;
      step();
      cfg_we = 1'b0;
      chk("pre_reset_pending", 8'(pending), 8'h02);
      chk("pre_reset_blink", 8'(blink), 8'({ch1_lvl(cyc), 1'b0}));
      reset = 1'b1;
      step();
      cyc = 0;
      reset = 1'b0;
      chk("rereset_blink", 8'(blink), 8'h03);
      chk("rereset_pending", 8'(pending), 8'h00);
      chk("rereset_pending3", 8'(pending3), 8'h00);
      for (int c = 0; c < 40; c++) begin
         chk("rereset_timing", 8'(blink), 8'({2{def_lvl(c)}}));
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
